// File: rtl/aes128_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module  : aes128_line_unpacker
// Brief   : Line FIFO that splits 512-bit cache lines into four 128-bit blocks
// Revision: 1.0  initial release
// ============================================================================
module aes128_line_unpacker #(
    parameter int DEPTH       = 8,
    parameter int AFULL_SLACK = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [511:0]      line_in,
    input  logic              line_valid_in,
    output logic              line_afull,
    output logic [127:0]      word_out,
    output logic              word_valid_out,
    input  logic              word_ready_in,
    output logic [CNT_W-1:0]  lines_in_cnt,
    output logic [CNT_W-1:0]  words_out_cnt,
    output logic              overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] c_full       = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] c_afull_lvl  = OCC_W'(DEPTH - AFULL_SLACK);

    logic [511:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [1:0]        r_lane;
    logic [CNT_W-1:0]  r_lines_cnt;
    logic [CNT_W-1:0]  r_words_cnt;
    logic              r_err;
    logic              r_afull;

    logic              w_valid;
    logic              w_push;
    logic              w_ovf;
    logic              w_xfer;
    logic              w_pop;
    logic [OCC_W-1:0]  w_occ_next;
    logic [511:0]      w_head;
    logic [127:0]      w_word;

    // Acceptance uses the registered occupancy only, so a same-cycle pop
    // never makes room for a line that arrives while full.
    assign w_valid = (r_occ != '0);
    assign w_push  = line_valid_in && (r_occ != c_full);
    assign w_ovf   = line_valid_in && (r_occ == c_full);
    assign w_xfer  = w_valid && word_ready_in;
    assign w_pop   = w_xfer && (r_lane == 2'd3);

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + OCC_W'(1);
            2'b01:   w_occ_next = r_occ - OCC_W'(1);
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset && !clear) begin
            r_mem[r_wr_ptr] <= line_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_lane      <= 2'd0;
            r_lines_cnt <= '0;
            r_words_cnt <= '0;
            r_err       <= 1'b0;
            r_afull     <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_afull <= (w_occ_next >= c_afull_lvl);
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
                r_lines_cnt <= r_lines_cnt + CNT_W'(1);
            end
            if (w_ovf) begin
                r_err <= 1'b1;
            end
            if (w_xfer) begin
                r_lane      <= r_lane + 2'd1;
                r_words_cnt <= r_words_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_word = '0;
        if (w_valid) begin
            case (r_lane)
                2'd0:    w_word = w_head[127:0];
                2'd1:    w_word = w_head[255:128];
                2'd2:    w_word = w_head[383:256];
                default: w_word = w_head[511:384];
            endcase
        end
    end

    assign word_out       = w_word;
    assign word_valid_out = w_valid;
    assign line_afull     = r_afull;
    assign lines_in_cnt   = r_lines_cnt;
    assign words_out_cnt  = r_words_cnt;
    assign overflow_err   = r_err;

endmodule
`default_nettype wire
